// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request and data-RAM bus bundle for mem_access_unit
interface mem_access_unit_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10
);
  logic               i_valid;
  logic               i_mem_read;
  logic               i_mem_write;
  logic [1:0]         i_data_size;
  logic               i_unsigned;
  logic [NB_ADDR-1:0] i_addr;
  logic [NB_DATA-1:0] i_wdata;
  logic [NB_DATA-1:0] o_rdata;
  logic               o_rdata_valid;
  logic               o_stall;
  logic               o_err;
  logic [NB_ADDR-3:0] o_mem_addr;
  logic               o_mem_re;
  logic [3:0]         o_mem_we;
  logic [NB_DATA-1:0] o_mem_wdata;
  logic [NB_DATA-1:0] i_mem_rdata;

  // pipeline requester plus data RAM
  modport master (
    output i_valid, i_mem_read, i_mem_write, i_data_size, i_unsigned, i_addr, i_wdata,
    output i_mem_rdata,
    input  o_rdata, o_rdata_valid, o_stall, o_err,
    input  o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata
  );

  // the access unit
  modport slave (
    input  i_valid, i_mem_read, i_mem_write, i_data_size, i_unsigned, i_addr, i_wdata,
    input  i_mem_rdata,
    output o_rdata, o_rdata_valid, o_stall, o_err,
    output o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with split unaligned accesses
module mem_access_unit #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10
) (
  input logic              i_clk,
  input logic              i_rst_n,
  mem_access_unit_if.slave bus
);
  localparam int NB_WADDR = NB_ADDR - 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LD_LO = 2'd1;
  localparam logic [1:0] LD_HI = 2'd2;
  localparam logic [1:0] ST_HI = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [NB_ADDR-1:0]  addr_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic                split_q;
  logic [NB_DATA-1:0]  wdata_q;
  logic [NB_DATA-1:0]  lo_q;
  logic [NB_DATA-1:0]  rdata_q;

  logic [1:0]          sel_off;
  logic [1:0]          sel_size;
  logic [NB_DATA-1:0]  sel_wdata;
  logic [2:0]          nbytes;
  logic                split_now;
  logic [7:0]          mask_base;
  logic [7:0]          mask_wide;
  logic [2*NB_DATA-1:0] lanes_wide;
  logic                invalid;

  logic [NB_WADDR-1:0] w_in;
  logic [NB_WADDR-1:0] w_next;

  logic [2*NB_DATA-1:0] ld_pair;
  logic [NB_DATA-1:0]   ld_shift;
  logic [NB_DATA-1:0]   ld_result;

  logic                 stall, err, re, rvalid;
  logic [3:0]           we;
  logic [NB_WADDR-1:0]  maddr;
  logic [NB_DATA-1:0]   mwdata;

  assign w_in   = bus.i_addr[NB_ADDR-1:2];
  assign w_next = addr_q[NB_ADDR-1:2] + {{(NB_WADDR-1){1'b0}}, 1'b1};

  // Byte-lane view of the current store: live inputs when accepting, latched copy in ST_HI
  always_comb begin
    sel_off   = (state_q == IDLE) ? bus.i_addr[1:0]   : addr_q[1:0];
    sel_size  = (state_q == IDLE) ? bus.i_data_size   : size_q;
    sel_wdata = (state_q == IDLE) ? bus.i_wdata       : wdata_q;
    case (sel_size)
      2'b01:   nbytes = 3'd1;
      2'b10:   nbytes = 3'd2;
      2'b11:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
    split_now  = ({1'b0, sel_off} + nbytes) > 3'd4;
    mask_base  = (8'd1 << nbytes) - 8'd1;
    mask_wide  = mask_base << sel_off;
    lanes_wide = {{NB_DATA{1'b0}}, sel_wdata} << {sel_off, 3'b000};
    invalid    = bus.i_valid && ((bus.i_data_size == 2'b00) || (bus.i_mem_read && bus.i_mem_write));
  end

  // Align and extend the loaded bytes; the aligned case has no upper word
  always_comb begin
    ld_pair  = split_q ? {bus.i_mem_rdata, lo_q} : {{NB_DATA{1'b0}}, bus.i_mem_rdata};
    ld_shift = NB_DATA'(ld_pair >> {addr_q[1:0], 3'b000});
    case (size_q)
      2'b01:   ld_result = uns_q ? {{(NB_DATA-8){1'b0}}, ld_shift[7:0]}
                                 : {{(NB_DATA-8){ld_shift[7]}}, ld_shift[7:0]};
      2'b10:   ld_result = uns_q ? {{(NB_DATA-16){1'b0}}, ld_shift[15:0]}
                                 : {{(NB_DATA-16){ld_shift[15]}}, ld_shift[15:0]};
      default: ld_result = ld_shift;
    endcase
  end

  // Next-state and RAM/pipeline controls; everything forced quiet while reset is held
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    err     = 1'b0;
    re      = 1'b0;
    rvalid  = 1'b0;
    we      = 4'b0000;
    maddr   = '0;
    mwdata  = '0;
    case (state_q)
      IDLE: begin
        if (invalid) begin
          err = 1'b1;
        end else if (bus.i_valid && bus.i_mem_write) begin
          we     = mask_wide[3:0];
          mwdata = lanes_wide[NB_DATA-1:0];
          maddr  = w_in;
          if (split_now) begin
            stall   = 1'b1;
            state_d = ST_HI;
          end
        end else if (bus.i_valid && bus.i_mem_read) begin
          re      = 1'b1;
          maddr   = w_in;
          stall   = 1'b1;
          state_d = split_now ? LD_LO : LD_HI;
        end
      end
      LD_LO: begin
        re      = 1'b1;
        maddr   = w_next;
        stall   = 1'b1;
        state_d = LD_HI;
      end
      LD_HI: begin
        rvalid  = 1'b1;
        state_d = IDLE;
      end
      ST_HI: begin
        we      = mask_wide[7:4];
        mwdata  = lanes_wide[2*NB_DATA-1:NB_DATA];
        maddr   = w_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!i_rst_n) begin
      state_d = IDLE;
      stall   = 1'b0;
      err     = 1'b0;
      re      = 1'b0;
      rvalid  = 1'b0;
      we      = 4'b0000;
      maddr   = '0;
      mwdata  = '0;
    end
  end

  // FSM state, request latch at accept, low-word capture and load result hold
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d != IDLE) begin
        addr_q  <= bus.i_addr;
        size_q  <= bus.i_data_size;
        uns_q   <= bus.i_unsigned;
        wdata_q <= bus.i_wdata;
        split_q <= split_now;
      end
      if (state_q == LD_LO) lo_q <= bus.i_mem_rdata;
      if (state_q == LD_HI) rdata_q <= ld_result;
    end
  end

  assign bus.o_rdata       = (state_q == LD_HI) ? ld_result : rdata_q;
  assign bus.o_rdata_valid = rvalid;
  assign bus.o_stall       = stall;
  assign bus.o_err         = err;
  assign bus.o_mem_addr    = maddr;
  assign bus.o_mem_re      = re;
  assign bus.o_mem_we      = we;
  assign bus.o_mem_wdata   = mwdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] ram [256];

  mem_access_unit_if #(.NB_DATA(32), .NB_ADDR(10)) bus ();

  mem_access_unit #(.NB_DATA(32), .NB_ADDR(10)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous byte-writable data RAM with a bench-side preload port
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    if (bus.o_mem_re) bus.i_mem_rdata <= ram[bus.o_mem_addr];
    for (int b = 0; b < 4; b++)
      if (bus.o_mem_we[b]) ram[bus.o_mem_addr][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [9:0] a, input logic [31:0] wd);
    bus.i_valid     = v;
    bus.i_mem_read  = rd;
    bus.i_mem_write = wr;
    bus.i_data_size = sz;
    bus.i_unsigned  = uns;
    bus.i_addr      = a;
    bus.i_wdata     = wd;
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    step();
    pre_we   = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pre_we      = 1'b0;
    pre_addr    = '0;
    pre_data    = '0;
    rst_n       = 1'b0;
    // garbage request during reset must not leak to outputs
    req(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 10'h3FD, 32'hFFFF_FFFF);
    chk("rst_we",     {28'd0, bus.o_mem_we}, 32'h0);
    chk("rst_re",     {31'd0, bus.o_mem_re}, 32'h0);
    chk("rst_stall",  {31'd0, bus.o_stall}, 32'h0);
    chk("rst_err",    {31'd0, bus.o_err}, 32'h0);
    chk("rst_rvalid", {31'd0, bus.o_rdata_valid}, 32'h0);
    chk("rst_rdata",  bus.o_rdata, 32'h0);
    chk("rst_maddr",  {24'd0, bus.o_mem_addr}, 32'h0);
    chk("rst_mwdata", bus.o_mem_wdata, 32'h0);
    preload(8'd1,   32'h0000_8000);
    preload(8'd0,   32'h1122_3344);
    preload(8'd255, 32'hAABB_CCDD);
    preload(8'd4,   32'h0000_0000);
    preload(8'd5,   32'h1234_5678);
    rst_n = 1'b1;
    req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h0, 32'h0);
    step();

    // aligned SW 0x008
    req(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 10'h008, 32'hDEAD_BEEF);
    chk("sw_addr",  {24'd0, bus.o_mem_addr}, 32'd2);
    chk("sw_we",    {28'd0, bus.o_mem_we}, 32'hF);
    chk("sw_wdata", bus.o_mem_wdata, 32'hDEAD_BEEF);
    chk("sw_stall", {31'd0, bus.o_stall}, 32'h0);
    chk("sw_re",    {31'd0, bus.o_mem_re}, 32'h0);
    step();
    req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h0, 32'h0);
    chk("sw_ram2", ram[2], 32'hDEAD_BEEF);

    // LB 0x005 signed, then LBU back-to-back
    req(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 10'h005, 32'h0);
    chk("lb_re",    {31'd0, bus.o_mem_re}, 32'h1);
    chk("lb_addr",  {24'd0, bus.o_mem_addr}, 32'd1);
    chk("lb_stall", {31'd0, bus.o_stall}, 32'h1);
    chk("lb_we",    {28'd0, bus.o_mem_we}, 32'h0);
    step();
    chk("lb_valid", {31'd0, bus.o_rdata_valid}, 32'h1);
    chk("lb_stall2", {31'd0, bus.o_stall}, 32'h0);
    chk("lb_rdata", bus.o_rdata, 32'hFFFF_FF80);
    chk("lb_nore",  {31'd0, bus.o_mem_re}, 32'h0);
    step();
    req(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 10'h005, 32'h0);
    chk("lbu_stall", {31'd0, bus.o_stall}, 32'h1);
    step();
    chk("lbu_rdata", bus.o_rdata, 32'h0000_0080);
    chk("lbu_valid", {31'd0, bus.o_rdata_valid}, 32'h1);
    step();
    req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h0, 32'h0);
    chk("hold_valid", {31'd0, bus.o_rdata_valid}, 32'h0);
    chk("hold_rdata", bus.o_rdata, 32'h0000_0080);

    // split SH 0x007
    req(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 10'h007, 32'h0000_ABCD);
    chk("sh0_addr",  {24'd0, bus.o_mem_addr}, 32'd1);
    chk("sh0_we",    {28'd0, bus.o_mem_we}, 32'h8);
    chk("sh0_wdata", bus.o_mem_wdata, 32'hCD00_0000);
    chk("sh0_stall", {31'd0, bus.o_stall}, 32'h1);
    step();
    chk("sh1_addr",  {24'd0, bus.o_mem_addr}, 32'd2);
    chk("sh1_we",    {28'd0, bus.o_mem_we}, 32'h1);
    chk("sh1_wdata", bus.o_mem_wdata, 32'h0000_00AB);
    chk("sh1_stall", {31'd0, bus.o_stall}, 32'h0);
    step();
    req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h0, 32'h0);
    chk("sh_ram1", ram[1], 32'hCD00_8000);
    chk("sh_ram2", ram[2], 32'hDEAD_BEAB);

    // split LW 0x006
    preload(8'd1, 32'h4433_2211);
    preload(8'd2, 32'h8877_6655);
    req(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 10'h006, 32'h0);
    chk("lw0_addr",  {24'd0, bus.o_mem_addr}, 32'd1);
    chk("lw0_stall", {31'd0, bus.o_stall}, 32'h1);
    step();
    chk("lw1_addr",  {24'd0, bus.o_mem_addr}, 32'd2);
    chk("lw1_re",    {31'd0, bus.o_mem_re}, 32'h1);
    chk("lw1_stall", {31'd0, bus.o_stall}, 32'h1);
    step();
    chk("lw2_valid", {31'd0, bus.o_rdata_valid}, 32'h1);
    chk("lw2_rdata", bus.o_rdata, 32'h6655_4433);
    chk("lw2_stall", {31'd0, bus.o_stall}, 32'h0);
    step();

    // wrap: LW 0x3FE reads word 255 then word 0
    req(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 10'h3FE, 32'h0);
    chk("wr0_addr", {24'd0, bus.o_mem_addr}, 32'd255);
    step();
    chk("wr1_addr", {24'd0, bus.o_mem_addr}, 32'd0);
    step();
    chk("wr2_rdata", bus.o_rdata, 32'h3344_AABB);
    step();

    // invalid requests
    req(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 10'h010, 32'h0);
    chk("inv0_err",   {31'd0, bus.o_err}, 32'h1);
    chk("inv0_re",    {31'd0, bus.o_mem_re}, 32'h0);
    chk("inv0_we",    {28'd0, bus.o_mem_we}, 32'h0);
    chk("inv0_stall", {31'd0, bus.o_stall}, 32'h0);
    step();
    req(1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 10'h010, 32'h5555_5555);
    chk("inv1_err", {31'd0, bus.o_err}, 32'h1);
    chk("inv1_we",  {28'd0, bus.o_mem_we}, 32'h0);
    step();
    req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h0, 32'h0);
    chk("inv_drop", {31'd0, bus.o_err}, 32'h0);

    // reset during ST_HI of a split SW at 0x011
    req(1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 10'h011, 32'hCAFE_F00D);
    chk("rs0_we",    {28'd0, bus.o_mem_we}, 32'hE);
    chk("rs0_wdata", bus.o_mem_wdata, 32'hFEF0_0D00);
    step();
    chk("rs1_we",    {28'd0, bus.o_mem_we}, 32'h1);
    chk("rs1_wdata", bus.o_mem_wdata, 32'h0000_00CA);
    chk("rs1_addr",  {24'd0, bus.o_mem_addr}, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("rs_we",    {28'd0, bus.o_mem_we}, 32'h0);
    chk("rs_addr",  {24'd0, bus.o_mem_addr}, 32'h0);
    chk("rs_wdata", bus.o_mem_wdata, 32'h0);
    chk("rs_stall", {31'd0, bus.o_stall}, 32'h0);
    step();
    rst_n = 1'b1;
    req(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 10'h0, 32'h0);
    chk("rs_ram4", ram[4], 32'hFEF0_0D00);
    chk("rs_ram5", ram[5], 32'h1234_5678);
    chk("rs_rdata", bus.o_rdata, 32'h0);

    // normal LHU 0x002 after reset
    req(1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 10'h002, 32'h0);
    chk("lhu_stall", {31'd0, bus.o_stall}, 32'h1);
    chk("lhu_addr",  {24'd0, bus.o_mem_addr}, 32'd0);
    step();
    chk("lhu_valid", {31'd0, bus.o_rdata_valid}, 32'h1);
    chk("lhu_rdata", bus.o_rdata, 32'h0000_1122);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
